// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection (RUN/BUBBLE FSM) and flush squash.
// Optional performance counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  ctrl_in,
  input  logic [3:0]  alu_ctrl_in,
  input  logic [31:0] rd1_in,
  input  logic [31:0] rd2_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] pc4_in,
  input  logic [4:0]  rs_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic        valid_in,
  input  logic        flush,
  output logic [6:0]  ctrl_ex,
  output logic [3:0]  alu_ctrl_ex,
  output logic [31:0] rd1_ex,
  output logic [31:0] rd2_ex,
  output logic [31:0] imm_ex,
  output logic [31:0] pc4_ex,
  output logic [4:0]  rs_ex,
  output logic [4:0]  rt_ex,
  output logic [4:0]  rd_ex,
  output logic        valid_ex,
  output logic        stall,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [6:0]  ctrl_q, ctrl_d;
  logic [3:0]  alu_ctrl_q, alu_ctrl_d;
  logic [31:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc4_q, pc4_d;
  logic [4:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic        valid_q, valid_d;
  logic        load_use;
  logic        bubble;

  // Hazard detection against the load currently sitting in EX
  always_comb begin
    load_use = valid_q & ctrl_q[2] & valid_in & (rt_q != 5'd0) &
               ((rt_q == rs_in) | (rt_q == rt_in));
    stall    = rst_n & ~flush & (state_q == RUN) & load_use;
  end

  // Next-state and pipeline register load selection
  always_comb begin
    state_d = RUN;
    bubble  = 1'b0;
    if (flush) begin
      bubble  = 1'b1;
      state_d = RUN;
    end else if ((state_q == RUN) && load_use) begin
      bubble  = 1'b1;
      state_d = BUBBLE;
    end else begin
      bubble  = 1'b0;
      state_d = RUN;
    end
    // Bubbles zero every control bit, so RegWrite and MemWrite can never leak through
    ctrl_d     = (bubble || !valid_in) ? 7'd0 : ctrl_in;
    alu_ctrl_d = bubble ? 4'd0 : alu_ctrl_in;
    valid_d    = valid_in & ~bubble;
    rd1_d      = rd1_in;
    rd2_d      = rd2_in;
    imm_d      = imm_in;
    pc4_d      = pc4_in;
    rs_d       = rs_in;
    rt_d       = rt_in;
    rd_d       = rd_in;
  end

  // Pipeline and FSM state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      ctrl_q     <= 7'd0;
      alu_ctrl_q <= 4'd0;
      rd1_q      <= 32'd0;
      rd2_q      <= 32'd0;
      imm_q      <= 32'd0;
      pc4_q      <= 32'd0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      rd_q       <= 5'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      alu_ctrl_q <= alu_ctrl_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      pc4_q      <= pc4_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      valid_q    <= valid_d;
    end
  end

  assign ctrl_ex     = ctrl_q;
  assign alu_ctrl_ex = alu_ctrl_q;
  assign rd1_ex      = rd1_q;
  assign rd2_ex      = rd2_q;
  assign imm_ex      = imm_q;
  assign pc4_ex      = pc4_q;
  assign rs_ex       = rs_q;
  assign rt_ex       = rt_q;
  assign rd_ex       = rd_q;
  assign valid_ex    = valid_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, pass-through, load-use, flush and reset-in-bubble.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic [6:0]  ctrl_in;
  logic [3:0]  alu_ctrl_in;
  logic [31:0] rd1_in, rd2_in, imm_in, pc4_in;
  logic [4:0]  rs_in, rt_in, rd_in;
  logic        valid_in, flush;
  logic [6:0]  ctrl_ex;
  logic [3:0]  alu_ctrl_ex;
  logic [31:0] rd1_ex, rd2_ex, imm_ex, pc4_ex;
  logic [4:0]  rs_ex, rt_ex, rd_ex;
  logic        valid_ex, stall;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] ADD = 7'b1001000;
  localparam logic [6:0] LW  = 7'b0111100;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .alu_ctrl_in(alu_ctrl_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in), .pc4_in(pc4_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .valid_in(valid_in), .flush(flush),
    .ctrl_ex(ctrl_ex), .alu_ctrl_ex(alu_ctrl_ex), .rd1_ex(rd1_ex), .rd2_ex(rd2_ex),
    .imm_ex(imm_ex), .pc4_ex(pc4_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
    .valid_ex(valid_ex), .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] c, input logic [3:0] a, input logic [31:0] d1,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic v);
    ctrl_in = c; alu_ctrl_in = a; rd1_in = d1; rd2_in = d1 + 32'd1;
    imm_in = d1 + 32'd2; pc4_in = d1 + 32'd4;
    rs_in = s; rt_in = t; rd_in = d; valid_in = v;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    drive(7'h7F, 4'hF, 32'hFFFF_FFF0, 5'd31, 5'd31, 5'd31, 1'b1);
    tick(); tick();
    n_checks++; if (ctrl_ex !== 7'd0)     begin n_fail++; $display("FAIL reset_ctrl got %h want 00", ctrl_ex); end
    n_checks++; if (valid_ex !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_ex); end
    n_checks++; if ({rd1_ex, rd2_ex, imm_ex, pc4_ex} !== 128'd0)
                                          begin n_fail++; $display("FAIL reset_data got %h want 0", {rd1_ex, rd2_ex, imm_ex, pc4_ex}); end
    n_checks++; if ({alu_ctrl_ex, rs_ex, rt_ex, rd_ex} !== 19'd0)
                                          begin n_fail++; $display("FAIL reset_fields got %h want 0", {alu_ctrl_ex, rs_ex, rt_ex, rd_ex}); end
    n_checks++; if (stall !== 1'b0)       begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_checks++; if ({stall_cnt, flush_cnt} !== 32'd0)
                                          begin n_fail++; $display("FAIL reset_cnt got %h want 0", {stall_cnt, flush_cnt}); end
    rst_n = 1'b1;
    drive(7'd0, 4'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    n_checks++; if (stall !== 1'b0)       begin n_fail++; $display("FAIL post_reset_stall got %b want 0", stall); end
  endtask

  task automatic test_pass_through();
    drive(ADD, 4'h2, 32'h5, 5'd1, 5'd2, 5'd3, 1'b1);
    n_checks++; if (stall !== 1'b0)       begin n_fail++; $display("FAIL pass_stall got %b want 0", stall); end
    tick();
    n_checks++; if (ctrl_ex !== ADD)      begin n_fail++; $display("FAIL pass_ctrl got %b want %b", ctrl_ex, ADD); end
    n_checks++; if (alu_ctrl_ex !== 4'h2) begin n_fail++; $display("FAIL pass_alu got %h want 2", alu_ctrl_ex); end
    n_checks++; if (rd1_ex !== 32'h5)     begin n_fail++; $display("FAIL pass_rd1 got %h want 5", rd1_ex); end
    n_checks++; if ({rd2_ex, imm_ex, pc4_ex} !== {32'h6, 32'h7, 32'h9})
                                          begin n_fail++; $display("FAIL pass_data got %h want 6/7/9", {rd2_ex, imm_ex, pc4_ex}); end
    n_checks++; if ({rs_ex, rt_ex, rd_ex} !== {5'd1, 5'd2, 5'd3})
                                          begin n_fail++; $display("FAIL pass_regs got %h want 1/2/3", {rs_ex, rt_ex, rd_ex}); end
    n_checks++; if (valid_ex !== 1'b1)    begin n_fail++; $display("FAIL pass_valid got %b want 1", valid_ex); end
  endtask

  task automatic test_valid_in_zero();
    drive(7'h7F, 4'h6, 32'h100, 5'd4, 5'd5, 5'd6, 1'b0);
    tick();
    n_checks++; if (ctrl_ex !== 7'd0)     begin n_fail++; $display("FAIL inval_ctrl got %h want 00", ctrl_ex); end
    n_checks++; if (valid_ex !== 1'b0)    begin n_fail++; $display("FAIL inval_valid got %b want 0", valid_ex); end
    n_checks++; if (rd1_ex !== 32'h100)   begin n_fail++; $display("FAIL inval_rd1 got %h want 100", rd1_ex); end
  endtask

  task automatic test_load_use();
    drive(LW, 4'h2, 32'h20, 5'd1, 5'd8, 5'd0, 1'b1);
    tick();
    drive(ADD, 4'h2, 32'h30, 5'd8, 5'd2, 5'd9, 1'b1);
    n_checks++; if (stall !== 1'b1)       begin n_fail++; $display("FAIL lu_stall got %b want 1", stall); end
    tick();
    n_checks++; if (ctrl_ex !== 7'd0)     begin n_fail++; $display("FAIL lu_bubble_ctrl got %b want 0", ctrl_ex); end
    n_checks++; if ({valid_ex, alu_ctrl_ex} !== 5'd0)
                                          begin n_fail++; $display("FAIL lu_bubble_valid got %h want 0", {valid_ex, alu_ctrl_ex}); end
    n_checks++; if (rs_ex !== 5'd8)       begin n_fail++; $display("FAIL lu_bubble_rs got %0d want 8", rs_ex); end
    n_checks++; if (stall !== 1'b0)       begin n_fail++; $display("FAIL lu_second_stall got %b want 0", stall); end
    tick();
    n_checks++; if (ctrl_ex !== ADD)      begin n_fail++; $display("FAIL lu_reload_ctrl got %b want %b", ctrl_ex, ADD); end
    n_checks++; if ({valid_ex, rs_ex, rd_ex} !== {1'b1, 5'd8, 5'd9})
                                          begin n_fail++; $display("FAIL lu_reload_regs got %h want 1/8/9", {valid_ex, rs_ex, rd_ex}); end
    n_checks++; if (stall_cnt !== (PERF ? 16'd1 : 16'd0))
                                          begin n_fail++; $display("FAIL lu_stall_cnt got %0d want %0d", stall_cnt, PERF ? 1 : 0); end
  endtask

  task automatic test_rt_zero();
    drive(LW, 4'h2, 32'h40, 5'd1, 5'd0, 5'd0, 1'b1);
    tick();
    drive(ADD, 4'h2, 32'h50, 5'd0, 5'd3, 5'd4, 1'b1);
    n_checks++; if (stall !== 1'b0)       begin n_fail++; $display("FAIL rt0_stall got %b want 0", stall); end
    tick();
    n_checks++; if ({valid_ex, ctrl_ex} !== {1'b1, ADD})
                                          begin n_fail++; $display("FAIL rt0_load got %h want %h", {valid_ex, ctrl_ex}, {1'b1, ADD}); end
  endtask

  task automatic test_flush_hazard();
    drive(LW, 4'h2, 32'h60, 5'd1, 5'd8, 5'd0, 1'b1);
    tick();
    flush = 1'b1;
    drive(ADD, 4'h2, 32'h70, 5'd8, 5'd2, 5'd9, 1'b1);
    n_checks++; if (stall !== 1'b0)       begin n_fail++; $display("FAIL fl_stall got %b want 0", stall); end
    tick();
    flush = 1'b0;
    n_checks++; if ({valid_ex, ctrl_ex} !== 8'd0)
                                          begin n_fail++; $display("FAIL fl_bubble got %h want 0", {valid_ex, ctrl_ex}); end
    n_checks++; if (flush_cnt !== (PERF ? 16'd1 : 16'd0))
                                          begin n_fail++; $display("FAIL fl_flush_cnt got %0d want %0d", flush_cnt, PERF ? 1 : 0); end
    n_checks++; if (stall_cnt !== (PERF ? 16'd1 : 16'd0))
                                          begin n_fail++; $display("FAIL fl_stall_cnt got %0d want %0d", stall_cnt, PERF ? 1 : 0); end
    tick();
    n_checks++; if ({valid_ex, ctrl_ex} !== {1'b1, ADD})
                                          begin n_fail++; $display("FAIL fl_resume got %h want %h", {valid_ex, ctrl_ex}, {1'b1, ADD}); end
  endtask

  task automatic test_flush_in_bubble();
    drive(LW, 4'h2, 32'h80, 5'd1, 5'd8, 5'd0, 1'b1);
    tick();
    drive(ADD, 4'h2, 32'h90, 5'd8, 5'd2, 5'd9, 1'b1);
    n_checks++; if (stall !== 1'b1)       begin n_fail++; $display("FAIL fb_stall got %b want 1", stall); end
    tick();
    flush = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0)       begin n_fail++; $display("FAIL fb_bubble_stall got %b want 0", stall); end
    tick();
    flush = 1'b0;
    n_checks++; if ({valid_ex, ctrl_ex, alu_ctrl_ex} !== 12'd0)
                                          begin n_fail++; $display("FAIL fb_squash got %h want 0", {valid_ex, ctrl_ex, alu_ctrl_ex}); end
    n_checks++; if ({stall_cnt, flush_cnt} !== (PERF ? {16'd2, 16'd2} : 32'd0))
                                          begin n_fail++; $display("FAIL fb_cnt got %h want %h", {stall_cnt, flush_cnt}, PERF ? {16'd2, 16'd2} : 32'd0); end
  endtask

  task automatic test_reset_mid_bubble();
    drive(LW, 4'h2, 32'hA0, 5'd1, 5'd8, 5'd0, 1'b1);
    tick();
    drive(ADD, 4'h2, 32'hB0, 5'd8, 5'd2, 5'd9, 1'b1);
    n_checks++; if (stall !== 1'b1)       begin n_fail++; $display("FAIL rb_stall got %b want 1", stall); end
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0)       begin n_fail++; $display("FAIL rb_stall_in_reset got %b want 0", stall); end
    tick();
    n_checks++; if ({valid_ex, ctrl_ex, rs_ex, rd1_ex} !== 45'd0)
                                          begin n_fail++; $display("FAIL rb_outputs got %h want 0", {valid_ex, ctrl_ex, rs_ex, rd1_ex}); end
    n_checks++; if ({stall_cnt, flush_cnt} !== 32'd0)
                                          begin n_fail++; $display("FAIL rb_cnt got %h want 0", {stall_cnt, flush_cnt}); end
    rst_n = 1'b1;
    drive(ADD, 4'h2, 32'hC0, 5'd1, 5'd2, 5'd3, 1'b1);
    n_checks++; if (stall !== 1'b0)       begin n_fail++; $display("FAIL rb_post_stall got %b want 0", stall); end
    tick();
    n_checks++; if ({valid_ex, ctrl_ex, rd1_ex} !== {1'b1, ADD, 32'hC0})
                                          begin n_fail++; $display("FAIL rb_latency got %h want %h", {valid_ex, ctrl_ex, rd1_ex}, {1'b1, ADD, 32'hC0}); end
    drive(LW, 4'h2, 32'hD0, 5'd1, 5'd8, 5'd0, 1'b1);
    tick();
    drive(ADD, 4'h2, 32'hE0, 5'd2, 5'd8, 5'd9, 1'b1);
    n_checks++; if (stall !== 1'b1)       begin n_fail++; $display("FAIL rb_run_hazard got %b want 1", stall); end
    tick();
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_valid_in_zero();
    test_load_use();
    test_rt_zero();
    test_flush_hazard();
    test_flush_in_bubble();
    test_reset_mid_bubble();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
